// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified I/D memory port arbiter: owner encoding and fetch byte-enable.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant logic: data wins over fetch; with MEM_ARB_FAIR_EN a streak
// counter forces one fetch grant after MAX_DATA_STREAK data grants while fetch waits.
module mem_arb_grant #(
    parameter int MAX_DATA_STREAK = 4
) (
`ifdef MEM_ARB_FAIR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic if_req,
    input  logic d_req,
    input  logic halt_q,
    output logic if_gnt,
    output logic d_gnt
);

    if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 15) begin : g_streak_range
        $error("MAX_DATA_STREAK must be within 1..15");
    end

    logic fetch_ok_s;
    assign fetch_ok_s = if_req & ~halt_q;

`ifdef MEM_ARB_FAIR_EN
    logic [3:0] streak_r;
    logic [3:0] streak_nxt_s;
    logic       fetch_wins_s;

    assign fetch_wins_s = fetch_ok_s && (streak_r == 4'(MAX_DATA_STREAK));

    // Grant decision with the fairness override.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (fetch_wins_s) begin
            if_gnt = 1'b1;
        end else begin
            d_gnt  = d_req;
            if_gnt = fetch_ok_s & ~d_req;
        end
    end

    // Streak update: only data grants that make a live fetch wait count.
    always_comb begin
        streak_nxt_s = streak_r;
        if (if_gnt || !if_req) begin
            streak_nxt_s = 4'd0;
        end else if (d_gnt && fetch_ok_s) begin
            streak_nxt_s = streak_r + 4'd1;
        end else begin
            streak_nxt_s = streak_r;
        end
    end

    // Streak counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_r <= 4'd0;
        end else begin
            streak_r <= streak_nxt_s;
        end
    end
`else
    // Strict data priority; fetch may starve under continuous data traffic.
    always_comb begin
        d_gnt  = d_req;
        if_gnt = fetch_ok_s & ~d_req;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between fetch and load/store, steering each
// read back to its owner one cycle later. Optional fairness: define MEM_ARB_FAIR_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    input  logic              halt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    owner_e owner_r;
    logic   halt_q_r;
    logic   if_rvalid_r;
    logic   d_rvalid_r;
    logic   if_gnt_s;
    logic   d_gnt_s;

    mem_arb_grant #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_grant (
`ifdef MEM_ARB_FAIR_EN
        .clk    (clk),
        .rst    (rst),
`endif
        .if_req (if_req),
        .d_req  (d_req),
        .halt_q (halt_q_r),
        .if_gnt (if_gnt_s),
        .d_gnt  (d_gnt_s)
    );

    assign if_gnt = if_gnt_s;
    assign d_gnt  = d_gnt_s;

    // Memory port mux: the granted requester drives the port, otherwise all zero.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_be    = 4'h0;
        mem_wdata = 32'h0;
        if (d_gnt_s) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_be    = d_be;
            mem_wdata = d_wdata;
        end else if (if_gnt_s) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
            mem_be   = FETCH_BE;
        end else begin
            mem_en = 1'b0;
        end
    end

    // Owner, sticky halt and response-valid registers; reset drops any outstanding response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_r     <= OWN_NONE;
            halt_q_r    <= 1'b0;
            if_rvalid_r <= 1'b0;
            d_rvalid_r  <= 1'b0;
        end else begin
            halt_q_r    <= halt_q_r | halt;
            if_rvalid_r <= if_gnt_s;
            d_rvalid_r  <= d_gnt_s;
            if (d_gnt_s) begin
                owner_r <= OWN_DATA;
            end else if (if_gnt_s) begin
                owner_r <= OWN_IF;
            end else begin
                owner_r <= OWN_NONE;
            end
        end
    end

    assign if_rvalid = if_rvalid_r;
    assign d_rvalid  = d_rvalid_r;

    // Read data steering: the memory word goes to the owner of last cycle's access only.
    always_comb begin
        if_rdata = 32'h0;
        d_rdata  = 32'h0;
        case (owner_r)
            OWN_IF:   if_rdata = mem_rdata;
            OWN_DATA: d_rdata  = mem_rdata;
            default: begin
                if_rdata = 32'h0;
                d_rdata  = 32'h0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-enabled synchronous-read memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        halt;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:255];

    mem_port_arbiter #(
        .ADDR_W          (32),
        .MAX_DATA_STREAK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_be      (d_be),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .halt      (halt),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory with byte-enabled writes.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
            mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_be = 4'h0; d_wdata = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4]    = 32'h00500093;
        mem[64]   = 32'hCAFEF00D;
        mem[65]   = 32'hAAAABBBB;
        mem_rdata = 32'h0;
        halt      = 1'b0;
        idle();
        rst = 1'b1;
        #1;
        check("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("rst_d_rvalid",  {31'd0, d_rvalid},  32'd0);
        check("rst_mem_en",    {31'd0, mem_en},    32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // single fetch
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        check("fetch_gnt",   {31'd0, if_gnt}, 32'd1);
        check("fetch_dgnt",  {31'd0, d_gnt},  32'd0);
        check("fetch_en",    {31'd0, mem_en}, 32'd1);
        check("fetch_addr",  mem_addr,        32'h10);
        check("fetch_be",    {28'd0, mem_be}, 32'hF);
        check("fetch_we",    {31'd0, mem_we}, 32'd0);
        tick();
        idle();
        #1;
        check("fetch_rvalid", {31'd0, if_rvalid}, 32'd1);
        check("fetch_rdata",  if_rdata,           32'h00500093);
        check("fetch_d_rv",   {31'd0, d_rvalid},  32'd0);
        check("fetch_d_rd",   d_rdata,            32'h0);
        check("idle_addr",    mem_addr,           32'h0);
        check("idle_en",      {31'd0, mem_en},    32'd0);
        tick();

        // conflict: load wins, fetch granted the following cycle
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
        #1;
        check("conf_dgnt",  {31'd0, d_gnt},  32'd1);
        check("conf_ifgnt", {31'd0, if_gnt}, 32'd0);
        check("conf_addr",  mem_addr,        32'h100);
        tick();
        d_req = 1'b0;
        #1;
        check("conf_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("conf_d_rdata",  d_rdata,           32'hCAFEF00D);
        check("conf_if_rdata", if_rdata,          32'h0);
        check("conf_ifgnt2",   {31'd0, if_gnt},   32'd1);
        check("conf_addr2",    mem_addr,          32'h20);
        tick();
        idle();
        #1;
        check("conf_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        check("conf_d_rvalid2", {31'd0, d_rvalid},  32'd0);
        tick();

        // store then fetch of the same word
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h104; d_be = 4'b0011; d_wdata = 32'h1234;
        #1;
        check("st_we",    {31'd0, mem_we}, 32'd1);
        check("st_be",    {28'd0, mem_be}, 32'h3);
        check("st_wdata", mem_wdata,       32'h1234);
        tick();
        idle();
        if_req = 1'b1; if_addr = 32'h104;
        #1;
        check("st_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("st_ifgnt",  {31'd0, if_gnt},   32'd1);
        tick();
        idle();
        #1;
        check("st_readback", if_rdata, 32'hAAAA1234);
        tick();

        // reset in the response cycle drops the response
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        check("rm_gnt", {31'd0, if_gnt}, 32'd1);
        tick();
        idle();
        rst = 1'b1;
        #1;
        check("rm_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("rm_rdata",  if_rdata,           32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("rm_after", {31'd0, if_rvalid}, 32'd0);

        // continuous contention
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
        for (int c = 0; c < 10; c++) begin
            #1;
`ifdef MEM_ARB_FAIR_EN
            check($sformatf("fair_if_%0d", c), {31'd0, if_gnt}, (c % 5 == 4) ? 32'd1 : 32'd0);
            check($sformatf("fair_d_%0d", c),  {31'd0, d_gnt},  (c % 5 == 4) ? 32'd0 : 32'd1);
`else
            check($sformatf("strict_if_%0d", c), {31'd0, if_gnt}, 32'd0);
            check($sformatf("strict_d_%0d", c),  {31'd0, d_gnt},  32'd1);
`endif
            tick();
        end
        idle();
        tick();

        // halt pulse blocks fetch from the next cycle, data still served
        if_req = 1'b1; if_addr = 32'h10; halt = 1'b1;
        #1;
        check("halt_gnt_n", {31'd0, if_gnt}, 32'd1);
        tick();
        halt = 1'b0;
        #1;
        check("halt_gnt_n1", {31'd0, if_gnt},    32'd0);
        check("halt_rvalid", {31'd0, if_rvalid}, 32'd1);
        check("halt_rdata",  if_rdata,           32'h00500093);
        tick(); tick();
        check("halt_gnt_n3", {31'd0, if_gnt}, 32'd0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
        #1;
        check("halt_dgnt", {31'd0, d_gnt}, 32'd1);
        tick();
        d_req = 1'b0;
        #1;
        check("halt_d_rdata", d_rdata,         32'hCAFEF00D);
        check("halt_ifgnt",   {31'd0, if_gnt}, 32'd0);
        tick();

        // reset clears halt
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("unhalt_gnt", {31'd0, if_gnt}, 32'd1);
        tick();
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
